// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one port of a 64x8 dual-port RAM among NREQ
// single-beat requesters. The winning command is registered onto the RAM
// port. Read data returns with a one-hot rvalid two cycles after the accept.
module dpram_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_data,
  output logic              ram_we,
  input  logic [DW-1:0]      ram_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  // Round-robin pointer: the index searched first on the next arbitration.
  logic [IW-1:0] ptr;

  // Combinational arbitration result.
  logic [IW-1:0] win;
  logic          found;

  // A read was issued at the last edge, and which requester issued it.
  logic          rd_issued_p1;
  logic [IW-1:0] rd_owner_p1;

  // Index increment, wrapping modulo NREQ.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  // Search req from ptr upward, wrapping; the first set bit wins.
  always_comb begin
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = next_idx(idx);
    end
  end

  assign gnt = found ? (ONE << win) : '0;

  // Read data is the RAM's registered output, qualified by rvalid.
  assign rdata = ram_q;

  // Accept stage (p0 -> p1): register the winning command onto the RAM port
  // and remember whether a read is in flight. The read-return strobe is
  // produced one edge later, aligned with the RAM's registered q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      rd_issued_p1 <= 1'b0;
      rd_owner_p1  <= '0;
      rvalid       <= '0;
    end else begin
      // p1 -> p2: RAM samples the address now; q is valid in the next cycle.
      rvalid <= rd_issued_p1 ? (ONE << rd_owner_p1) : '0;
      if (found) begin
        ptr          <= next_idx(win);
        ram_addr     <= req_addr[win*AW +: AW];
        ram_data     <= req_wdata[win*DW +: DW];
        ram_we       <= req_we[win];
        rd_issued_p1 <= ~req_we[win];
        rd_owner_p1  <= win;
      end else begin
        // Idle: address holds, the RAM does a harmless read that is ignored.
        ram_we       <= 1'b0;
        rd_issued_p1 <= 1'b0;
      end
    end
  end

endmodule
